// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive monitor.
//   rx_state_e : receiver FSM states
//   HALF_BIT   : half-bit offset for the default bit period
//   cnt_width  : bit width of a down-counter that must hold n-1
//   half_bit   : half-bit offset for an arbitrary bit period
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned HALF_BIT         = DEF_CLKS_PER_BIT / 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned half_bit(input int unsigned cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO for received bytes.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   push_i   : write wdata_i (accepted when not full, or full with a pop)
//   wdata_i  : write data
//   pop_i    : remove the head entry (ignored when empty)
//   rdata_o  : head entry, '0 while empty
//   full_o   : all DEPTH entries occupied
//   empty_o  : no entries
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    // When full, a same-cycle pop frees the slot being written.
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a byte FIFO and sticky error flags.
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   rx        : serial line, idle high
//   rx_data   : FIFO head byte (first-word-fall-through)
//   rx_valid  : FIFO not empty
//   rx_ready  : consumer accepts rx_data when rx_valid is high
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a byte was dropped on a full FIFO
//   clear_err : synchronous clear of both flags (wins over a same-cycle set)
module uart_rx_monitor
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear_err
);

  localparam int unsigned   CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT) - 1);

  logic          sync1_q;
  logic          rs_q;
  logic          rs_dly_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tick;
  logic          push;
  logic          frame_set;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      rs_q     <= 1'b1;
      rs_dly_q <= 1'b1;
    end else begin
      sync1_q  <= rx;
      rs_q     <= sync1_q;
      rs_dly_q <= rs_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    tick      = (cnt_q == '0);
    unique case (state_q)
      IDLE: begin
        // Edge-triggered, so a line stuck low starts at most one frame.
        if (rs_dly_q && !rs_q) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d = CNT_FULL;
          if (rs_q) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d     = CNT_FULL;
          shift_d   = {rs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d   = CNT_FULL;
          state_d = IDLE;
          if (rs_q) begin
            push = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rstn),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (pop),
    .rdata_o(rx_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rx_valid = !fifo_empty;

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clear_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (frame_set) begin
        frame_err_d = 1'b1;
      end
      if (push && fifo_full && !pop) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clear_err;

  int checks = 0;
  int fails  = 0;
  int valid_rise;
  logic [7:0] got_q[$];

  uart_rx_monitor #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Record every accepted byte; sampled mid-cycle, the pop happens at the next rising edge.
  always @(negedge clk) begin
    if (rstn && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame of 160 cycles; rx_ready pulses for one cycle at pop_at, abort_at stops early.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int pop_at, input int abort_at);
    logic [9:0] frame;
    logic       prev;
    frame      = {stop, b, 1'b0};
    valid_rise = -1;
    prev       = rx_valid;
    for (int c = 0; c < 160; c++) begin
      if (c == abort_at) return;
      @(posedge clk);
      #1;
      rx = frame[c / 16];
      if (pop_at >= 0) begin
        if (c == pop_at) rx_ready = 1'b1;
        else if (c == pop_at + 1) rx_ready = 1'b0;
      end
      @(negedge clk);
      if (rx_valid && !prev && valid_rise < 0) valid_rise = c;
      prev = rx_valid;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; rx = 1'b1; rx_ready = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rstn = 1'b1;
    idle(4);
  endtask

  task automatic test_two_bytes;
    got_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h55, 1'b1, -1, -1);
    checks++; if (valid_rise !== 155) begin fails++; $display("FAIL latency: got %0d expected 155", valid_rise); end
    idle(4);
    send_byte(8'hA3, 1'b1, -1, -1);
    idle(20);
    checks++; if (got_q.size() !== 2) begin fails++; $display("FAIL two_count: got %0d expected 2", got_q.size()); end
    checks++; if (got_q[0] !== 8'h55) begin fails++; $display("FAIL two_byte0: got %h expected 55", got_q[0]); end
    checks++; if (got_q[1] !== 8'hA3) begin fails++; $display("FAIL two_byte1: got %h expected a3", got_q[1]); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL two_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL two_overrun: got %b expected 0", overrun); end
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL two_valid_idle: got %b expected 0", rx_valid); end
  endtask

  task automatic test_false_start;
    got_q.delete();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL false_valid: got %b expected 0", rx_valid); end
    checks++; if (got_q.size() !== 0) begin fails++; $display("FAIL false_count: got %0d expected 0", got_q.size()); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL false_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL false_overrun: got %b expected 0", overrun); end
    send_byte(8'hC4, 1'b1, -1, -1);
    idle(20);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'hC4) begin fails++; $display("FAIL false_recover: got n=%0d %h expected n=1 c4", got_q.size(), got_q[0]); end
  endtask

  task automatic test_frame_err;
    got_q.delete();
    send_byte(8'h0F, 1'b0, -1, -1);
    idle(20);
    checks++; if (got_q.size() !== 0 || rx_valid !== 1'b0) begin fails++; $display("FAIL ferr_discard: got n=%0d valid=%b expected n=0 valid=0", got_q.size(), rx_valid); end
    checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ferr_overrun: got %b expected 0", overrun); end
    idle(10);
    checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    send_byte(8'h10, 1'b1, -1, -1);
    idle(20);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h10) begin fails++; $display("FAIL ferr_next: got n=%0d %h expected n=1 10", got_q.size(), got_q[0]); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_next_flag: got %b expected 0", frame_err); end
    // Clear held across a bad stop bit: the set is lost.
    got_q.delete();
    clear_err = 1'b1;
    send_byte(8'h3C, 1'b0, -1, -1);
    idle(20);
    clear_err = 1'b0;
    idle(2);
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear_priority: got %b expected 0", frame_err); end
    checks++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_clear_discard: got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_overrun;
    logic [7:0] b;
    got_q.delete();
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_byte(b, 1'b1, -1, -1);
      idle(4);
    end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_at_full: got %b expected 0", overrun); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin fails++; $display("FAIL ovr_head: got valid=%b %h expected valid=1 01", rx_valid, rx_data); end
    send_byte(8'h05, 1'b1, -1, -1);
    idle(20);
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (rx_data !== 8'h01) begin fails++; $display("FAIL ovr_head_stable: got %h expected 01", rx_data); end
    rx_ready = 1'b1;
    idle(10);
    checks++; if (got_q.size() !== 4) begin fails++; $display("FAIL ovr_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      b = 8'(i + 1);
      checks++; if (got_q[i] !== b) begin fails++; $display("FAIL ovr_drain%0d: got %h expected %h", i, got_q[i], b); end
    end
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_empty: got %b expected 0", rx_valid); end
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    got_q.delete();
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(exp_b[i], 1'b1, -1, -1);
      idle(4);
    end
    // Pop lands on the same rising edge as the push of 0x66.
    send_byte(8'h66, 1'b1, 154, -1);
    idle(20);
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin fails++; $display("FAIL b2b_pop: got n=%0d %h expected n=1 11", got_q.size(), got_q[0]); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin fails++; $display("FAIL b2b_head: got valid=%b %h expected valid=1 22", rx_valid, rx_data); end
    rx_ready = 1'b1;
    idle(10);
    checks++; if (got_q.size() !== 5) begin fails++; $display("FAIL b2b_count: got %0d expected 5", got_q.size()); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (got_q[i] !== exp_b[i]) begin fails++; $display("FAIL b2b_drain%0d: got %h expected %h", i, got_q[i], exp_b[i]); end
    end
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid_byte;
    got_q.delete();
    rx_ready = 1'b0;
    send_byte(8'h0F, 1'b0, -1, -1);
    idle(4);
    send_byte(8'h5A, 1'b1, -1, -1);
    idle(4);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A || frame_err !== 1'b1) begin fails++; $display("FAIL rst_pre: got valid=%b %h ferr=%b expected valid=1 5a ferr=1", rx_valid, rx_data, frame_err); end
    send_byte(8'h77, 1'b1, -1, 88);
    rstn = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_data: got %h expected 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_mid_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(200);
    checks++; if (rx_valid !== 1'b0 || got_q.size() !== 0) begin fails++; $display("FAIL rst_spurious: got valid=%b n=%0d expected valid=0 n=0", rx_valid, got_q.size()); end
    rx_ready = 1'b1;
    send_byte(8'h88, 1'b1, -1, -1);
    idle(20);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h88) begin fails++; $display("FAIL rst_after: got n=%0d %h expected n=1 88", got_q.size(), got_q[0]); end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
